// File: rtl/gate_response_checker.sv
// Self-test checker: sweeps every input vector into a combinational gate,
// waits for it to settle, samples the response against a truth table and
// reports error count, first failing vector and overall pass/fail.
module gate_response_checker #(
  parameter int unsigned              NIn          = 2,
  parameter logic [(1 << NIn) - 1:0]  Expected     = 4'b0111,
  parameter int unsigned              SettleCycles = 10
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic           dut_out_i,
  output logic [NIn-1:0] stim_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           pass_o,
  output logic [NIn:0]   err_count_o,
  output logic           fail_valid_o,
  output logic [NIn-1:0] fail_vector_o
);

  localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);
  localparam logic [NIn-1:0] LastStim = {NIn{1'b1}};

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NIn-1:0]  stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [NIn:0]    err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [NIn-1:0]  fail_vector_q, fail_vector_d;

  logic            mismatch;
  logic [NIn:0]    err_next;

  // An unknown or floating response must count as a failure, hence case inequality.
  assign mismatch = (dut_out_i !== Expected[stim_q]);
  assign err_next = err_q + {{NIn{1'b0}}, mismatch};

  // Next-state logic for the sweep controller and its result registers.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stim_d        = stim_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    err_d         = err_q;
    fail_valid_d  = fail_valid_q;
    fail_vector_d = fail_vector_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d       = StSettle;
          cnt_d         = CntLoad;
          stim_d        = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          err_d         = '0;
          fail_valid_d  = 1'b0;
          fail_vector_d = '0;
        end
      end
      StSettle: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          // Sample edge: score this vector, then advance or finish.
          err_d = err_next;
          if (mismatch && !fail_valid_q) begin
            fail_valid_d  = 1'b1;
            fail_vector_d = stim_q;
          end
          if (stim_q != LastStim) begin
            stim_d = stim_q + NIn'(1);
            cnt_d  = CntLoad;
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset that aborts any sweep.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      stim_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      fail_valid_q  <= 1'b0;
      fail_vector_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stim_q        <= stim_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      err_q         <= err_d;
      fail_valid_q  <= fail_valid_d;
      fail_vector_q <= fail_vector_d;
    end
  end

  assign stim_o        = stim_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign err_count_o   = err_q;
  assign fail_valid_o  = fail_valid_q;
  assign fail_vector_o = fail_vector_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: a default instance driven by a
// selectable gate model and a SettleCycles=1 instance with a faulty vector.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dut_out;
  logic [1:0] stim;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] fail_vector;

  logic       start2 = 1'b0;
  logic       dut_out2;
  logic [1:0] stim2;
  logic       busy2, done2, pass2, fail_valid2;
  logic [2:0] err_count2;
  logic [1:0] fail_vector2;

  // 0: Nand (correct), 1: And, 2: stuck-at-1
  int unsigned mode = 0;
  logic        bad_val;

  int tests_run = 0;
  int tests_failed = 0;

  always_comb begin
    case (mode)
      1:       dut_out = &stim;
      2:       dut_out = 1'b1;
      default: dut_out = ~&stim;
    endcase
  end

  assign dut_out2 = (stim2 == 2'd2) ? bad_val : ~&stim2;

  gate_response_checker #(
    .NIn(2), .Expected(4'b0111), .SettleCycles(10)
  ) u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .dut_out_i(dut_out),
    .stim_o(stim), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .fail_valid_o(fail_valid), .fail_vector_o(fail_vector)
  );

  gate_response_checker #(
    .NIn(2), .Expected(4'b0111), .SettleCycles(1)
  ) u_dut_fast (
    .clk_i(clk), .reset_i(reset), .start_i(start2), .dut_out_i(dut_out2),
    .stim_o(stim2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(err_count2), .fail_valid_o(fail_valid2), .fail_vector_o(fail_vector2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge (E0); returns at E0+1ns.
  task automatic start_sweep();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count edges until done rises, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic probe;
    // Use a real X where the simulator keeps one, otherwise the wrong level.
    probe = 1'bx;
    bad_val = $isunknown(probe) ? 1'bx : 1'b0;

    step();
    step();
    reset = 1'b0;
    check_eq("rst_stim", 32'(stim), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_pass", 32'(pass), 0);
    check_eq("rst_err", 32'(err_count), 0);
    check_eq("rst_fv", 32'(fail_valid), 0);
    check_eq("rst_fvec", 32'(fail_vector), 0);

    // T1: correct Nand, full sweep
    mode = 0;
    start_sweep();
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_stim0", 32'(stim), 0);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 9) check_eq("t1_stim_e9", 32'(stim), 0);
      if (k == 10 || k == 20 || k == 30) check_eq("t1_stim_step", 32'(stim), 32'(k / 10));
      if (k == 39) check_eq("t1_done_e39", 32'(done), 0);
    end
    check_eq("t1_done", 32'(done), 1);
    check_eq("t1_busy_end", 32'(busy), 0);
    check_eq("t1_pass", 32'(pass), 1);
    check_eq("t1_err", 32'(err_count), 0);
    check_eq("t1_fv", 32'(fail_valid), 0);
    check_eq("t1_stim_end", 32'(stim), 3);

    // T2: And gate mismatches every vector
    mode = 1;
    start_sweep();
    check_eq("t2_done_clr", 32'(done), 0);
    wait_done(n);
    check_eq("t2_latency", 32'(n), 40);
    check_eq("t2_err", 32'(err_count), 4);
    check_eq("t2_pass", 32'(pass), 0);
    check_eq("t2_fv", 32'(fail_valid), 1);
    check_eq("t2_fvec", 32'(fail_vector), 0);

    // T3: stuck-at-1 fails only vector 3
    mode = 2;
    start_sweep();
    wait_done(n);
    check_eq("t3_latency", 32'(n), 40);
    check_eq("t3_err", 32'(err_count), 1);
    check_eq("t3_fvec", 32'(fail_vector), 3);
    check_eq("t3_pass", 32'(pass), 0);

    // T4: start while busy ignored; restart from DONE clears results
    mode = 1;
    start_sweep();
    repeat (14) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t4_busy_mid", 32'(busy), 1);
    check_eq("t4_stim_mid", 32'(stim), 1);
    check_eq("t4_err_mid", 32'(err_count), 1);
    wait_done(n);
    check_eq("t4_latency", 32'(n + 15), 40);
    check_eq("t4_err", 32'(err_count), 4);
    start_sweep();
    check_eq("t4_re_done", 32'(done), 0);
    check_eq("t4_re_err", 32'(err_count), 0);
    check_eq("t4_re_fv", 32'(fail_valid), 0);
    check_eq("t4_re_busy", 32'(busy), 1);
    check_eq("t4_re_stim", 32'(stim), 0);
    wait_done(n);
    check_eq("t4_re_latency", 32'(n), 40);

    // T5: reset mid-sweep aborts without a result
    start_sweep();
    repeat (23) step();
    check_eq("t5_err_pre", 32'(err_count), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_err", 32'(err_count), 0);
    check_eq("t5_fv", 32'(fail_valid), 0);
    check_eq("t5_stim", 32'(stim), 0);
    repeat (50) step();
    check_eq("t5_no_done", 32'(done), 0);
    mode = 0;
    start_sweep();
    wait_done(n);
    check_eq("t5_latency", 32'(n), 40);
    check_eq("t5_pass", 32'(pass), 1);

    // T7: start held high restarts right after DONE; done lasts one cycle
    start = 1'b1;
    step();
    wait_done(n);
    check_eq("t7_latency", 32'(n), 40);
    step();
    start = 1'b0;
    check_eq("t7_done_pulse", 32'(done), 0);
    check_eq("t7_busy", 32'(busy), 1);

    // T6: SettleCycles=1 instance, bad response at vector 2
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 50) begin
      step();
      n++;
    end
    check_eq("t6_latency", 32'(n), 4);
    check_eq("t6_err", 32'(err_count2), 1);
    check_eq("t6_fvec", 32'(fail_vector2), 2);
    check_eq("t6_fv", 32'(fail_valid2), 1);
    check_eq("t6_pass", 32'(pass2), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
